// File: rtl/barcode_scan_overlay.sv
// Purpose : draws NUM_LINES horizontal scan markers over a 1-bpp barcode image, coloured by scan status.
// Latency : 1 clk for hs/vs/de/data together; scan_ok is an OR of registered state.
// Backpr. : none -- pixel stream, one pixel per clk, never stalls.
//
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset (release expected synchronous)
//   x_in, y_in [9:0]            pixel coordinates aligned with in_*
//   scan_en                     decoder success (level or pulse)
//   in_hs, in_vs, in_de         timing from the generator, vs active-high
//   in_data                     barcode pixel, 1 = bar
//   out_hs, out_vs, out_de      in_* delayed 1 clk
//   out_data [23:0]             RGB888 pixel
//   scan_ok                     OK status for LEDs
//
// Build option: define SCAN_BLINK_EN to make FAIL markers blink with a
// 2^BLINK_SHIFT frame half-period; otherwise FAIL markers are steady.
module barcode_scan_overlay #(
    parameter int          NUM_LINES   = 3,
    parameter int          LINE_Y0     = 4,
    parameter int          LINE_PITCH  = 5,
    parameter int          LINE_THICK  = 1,
    parameter int          HOLD_FRAMES = 30,
    parameter int          BLINK_SHIFT = 4,
    parameter logic [23:0] C_OK        = 24'h00ff00,
    parameter logic [23:0] C_FAIL      = 24'hff0000,
    parameter logic [23:0] C_BAR       = 24'h000000,
    parameter logic [23:0] C_BG        = 24'hffffff
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic        scan_en,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic        in_data,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [23:0] out_data,
    output logic        scan_ok
);

    // A zero hold still needs a 1-bit counter so the OK logic stays uniform.
    localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

    logic [HW-1:0] hold_cnt;
    logic          scan_en_r;
    logic          vs_d;
    logic          frame_tick;
    logic          marker_hit;
    int            y_val;
    logic [23:0]   base_colour;
    logic [23:0]   fail_colour;
    logic [23:0]   marker_colour;
    logic [23:0]   pix_next;

    // Markers span the full line width, so x only passes through.
    logic unused_x;
    assign unused_x = ^x_in;

    assign frame_tick = in_vs & ~vs_d;
    assign scan_ok    = scan_en_r | (hold_cnt != '0);
    assign y_val      = {22'd0, y_in};

    // Bounds stay full-precision integers: a marker placed at or beyond
    // 1024 must never alias back into the visible rows.
    always_comb begin
        marker_hit = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((LINE_Y0 + i * LINE_PITCH) < 1024 &&
                y_val >= (LINE_Y0 + i * LINE_PITCH) &&
                y_val <  (LINE_Y0 + i * LINE_PITCH + LINE_THICK)) begin
                marker_hit = 1'b1;
            end
        end
    end

`ifdef SCAN_BLINK_EN
    localparam int FW = BLINK_SHIFT + 1;
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    // Hidden half-period shows the underlying barcode pixel instead.
    assign fail_colour = frame_cnt[BLINK_SHIFT] ? C_FAIL : base_colour;
`else
    assign fail_colour = C_FAIL;
`endif

    always_comb begin
        base_colour   = in_data ? C_BAR : C_BG;
        marker_colour = scan_ok ? C_OK : fail_colour;
        pix_next      = 24'h000000;
        if (in_de) begin
            pix_next = marker_hit ? marker_colour : base_colour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            scan_en_r <= 1'b0;
            vs_d      <= 1'b0;
            out_hs    <= 1'b0;
            out_vs    <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= 24'h000000;
        end else begin
            vs_d      <= in_vs;
            scan_en_r <= scan_en;
            // A fresh scan reloads even when it lands on the frame tick.
            if (scan_en) begin
                hold_cnt <= HW'(HOLD_FRAMES);
            end else if (frame_tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            out_hs   <= in_hs;
            out_vs   <= in_vs;
            out_de   <= in_de;
            out_data <= pix_next;
        end
    end

endmodule
